deemph: RTL and testbench

DEEMPH -- requirements
Module: deemph

---
 rtl/deemph.sv | 110 +++++++++++
 tb/tb_deemph.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/deemph.sv
// rtl/deemph.sv - single-multiplier de-emphasis IIR filter between two FIFOs
module deemph #(
  parameter int                          DATA_SIZE = 32,
  parameter int                          BITS      = 10,
  parameter logic signed [DATA_SIZE-1:0] X_COEFF   = 178,
  parameter logic signed [DATA_SIZE-1:0] Y_COEFF   = 667
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic signed [DATA_SIZE-1:0] add_in_dout,
  input  logic                        add_in_empty,
  output logic                        add_in_rd_en,
  output logic signed [DATA_SIZE-1:0] deemph_out_din,
  input  logic                        deemph_out_full,
  output logic                        deemph_out_wr_en
);

  localparam logic [1:0] S_READ  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  logic [1:0]                  r_state;
  logic [1:0]                  r_tap;
  logic signed [DATA_SIZE-1:0] r_x;
  logic signed [DATA_SIZE-1:0] r_x_prev;
  logic signed [DATA_SIZE-1:0] r_y_prev;
  logic signed [DATA_SIZE-1:0] r_acc;
  logic signed [DATA_SIZE-1:0] r_result;

  logic signed [DATA_SIZE-1:0]   w_coef;
  logic signed [DATA_SIZE-1:0]   w_opnd;
  logic signed [2*DATA_SIZE-1:0] w_coef_ext;
  logic signed [2*DATA_SIZE-1:0] w_opnd_ext;
  logic signed [2*DATA_SIZE-1:0] w_prod;
  logic signed [DATA_SIZE-1:0]   w_term;
  logic signed [DATA_SIZE-1:0]   w_sum;
  logic                          w_rd;
  logic                          w_wr;

  // Tap select for the shared multiplier: x[n], then x[n-1], then y[n-1]
  always_comb begin
    w_coef = X_COEFF;
    w_opnd = r_x;
    case (r_tap)
      2'd1: w_opnd = r_x_prev;
      2'd2: begin
        w_coef = Y_COEFF;
        w_opnd = r_y_prev;
      end
      default: ;
    endcase
  end

  // Full-width signed product, arithmetic shift (floor), then truncate back to sample width
  assign w_coef_ext = {{DATA_SIZE{w_coef[DATA_SIZE-1]}}, w_coef};
  assign w_opnd_ext = {{DATA_SIZE{w_opnd[DATA_SIZE-1]}}, w_opnd};
  assign w_prod     = w_coef_ext * w_opnd_ext;
  assign w_term     = DATA_SIZE'(w_prod >>> BITS);
  assign w_sum      = r_acc + w_term;

  // Strobes are combinational so the FIFO word is consumed in the cycle it is seen;
  // the read strobe is also gated by reset so it stays low while reset is held.
  assign w_rd             = (r_state == S_READ) && !add_in_empty && reset;
  assign w_wr             = (r_state == S_WRITE) && !deemph_out_full;
  assign add_in_rd_en     = w_rd;
  assign deemph_out_wr_en = w_wr;
  assign deemph_out_din   = r_result;

  // READ/CALC/WRITE sequencer with accumulator and history; history moves only on a committed write
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_READ;
      r_tap    <= '0;
      r_x      <= '0;
      r_x_prev <= '0;
      r_y_prev <= '0;
      r_acc    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_READ: begin
          if (w_rd) begin
            r_x     <= add_in_dout;
            r_acc   <= '0;
            r_tap   <= '0;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_acc <= w_sum;
          if (r_tap == 2'd2) begin
            r_result <= w_sum;
            r_state  <= S_WRITE;
          end else begin
            r_tap <= r_tap + 2'd1;
          end
        end
        S_WRITE: begin
          if (w_wr) begin
            r_x_prev <= r_x;
            r_y_prev <= r_result;
            r_state  <= S_READ;
          end
        end
        default: r_state <= S_READ;
      endcase
    end
  end

endmodule

// File: tb/tb_deemph.sv
// tb/tb_deemph.sv - randomized scoreboard bench for deemph
module tb_deemph;

  localparam int     W    = 32;
  localparam int     FRAC = 10;
  localparam longint XC   = 178;
  localparam longint YC   = 667;

  logic                clock = 1'b0;
  logic                reset = 1'b0;
  logic signed [W-1:0] add_in_dout = '0;
  logic                add_in_empty = 1'b1;
  logic                add_in_rd_en;
  logic signed [W-1:0] deemph_out_din;
  logic                deemph_out_full = 1'b0;
  logic                deemph_out_wr_en;

  deemph dut (
    .clock           (clock),
    .reset           (reset),
    .add_in_dout     (add_in_dout),
    .add_in_empty    (add_in_empty),
    .add_in_rd_en    (add_in_rd_en),
    .deemph_out_din  (deemph_out_din),
    .deemph_out_full (deemph_out_full),
    .deemph_out_wr_en(deemph_out_wr_en)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int in_q[$];
  int outs[$];

  int xp = 0, yp = 0;
  bit in_flight = 0;
  int exp_y = 0, exp_rd = 0, exp_wr = 0, wdin = 0;
  int last_rd = -1;
  bit gap_clean = 0;
  int rd_count = 0;
  int rst_from = 0, rst_to = 3;
  bit prev_reset = 0;
  int full_from = -1, full_to = -2;
  int trig_stall_rd = -1, stall_len = 0, trig_rst_rd = -1;
  bit force_empty = 0, rand_empty = 0, rand_stall = 0;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int deq(input longint p);
    longint s;
    s = p >>> FRAC;
    return int'(s);
  endfunction

  function automatic int ref_y(input int x, input int x1, input int y1);
    return deq(XC * longint'(x)) + deq(XC * longint'(x1)) + deq(YC * longint'(y1));
  endfunction

  task automatic step();
    bit rel;
    int x;
    @(negedge clock);
    cyc++;
    reset = (cyc >= rst_from && cyc < rst_to) ? 1'b0 : 1'b1;
    rel = reset && !prev_reset;
    if (rand_empty) force_empty = ($urandom_range(0, 3) == 0);
    add_in_empty    = (in_q.size() == 0) || force_empty;
    add_in_dout     = (in_q.size() != 0) ? in_q[0] : int'($urandom());
    deemph_out_full = (cyc >= full_from && cyc <= full_to);
    #1;
    if (!reset) begin
      check("rst_rd_en", add_in_rd_en, 0);
      check("rst_wr_en", deemph_out_wr_en, 0);
      check("rst_dout", deemph_out_din, 0);
      xp = 0; yp = 0; in_flight = 0; last_rd = -1; gap_clean = 0; rd_count = 0;
    end else begin
      if (rel && !add_in_empty) check("first_rd_after_rst", add_in_rd_en, 1);
      if (add_in_rd_en || deemph_out_wr_en)
        check("rd_wr_exclusive", add_in_rd_en && deemph_out_wr_en, 0);
      if (add_in_empty) check("rd_while_empty", add_in_rd_en, 0);
      if (deemph_out_full) begin
        check("wr_while_full", deemph_out_wr_en, 0);
        check("rd_while_stalled", add_in_rd_en, 0);
      end
      if (in_flight && cyc >= exp_rd + 4) begin
        if (cyc == exp_rd + 4) wdin = deemph_out_din;
        else check("dout_stable", deemph_out_din, wdin);
      end
      if (in_flight && cyc == exp_wr) begin
        if (deemph_out_full) exp_wr++;
        else check("wr_due", deemph_out_wr_en, 1);
      end
      if (deemph_out_wr_en) begin
        if (!in_flight) check("wr_unexpected", 1, 0);
        else begin
          check("wr_cycle", cyc, exp_wr);
          check("dout", deemph_out_din, exp_y);
          outs.push_back(deemph_out_din);
          in_flight = 0;
        end
      end
      if (add_in_rd_en) begin
        x = in_q.pop_front();
        if (in_flight) check("rd_before_wr", 1, 0);
        if (last_rd >= 0 && gap_clean) check("rd_spacing", cyc - last_rd, 5);
        rd_count++;
        exp_y = ref_y(x, xp, yp);
        xp = x; yp = exp_y;
        exp_rd = cyc; exp_wr = cyc + 4; in_flight = 1;
        last_rd = cyc; gap_clean = 1;
        if (rd_count == trig_stall_rd) begin
          full_from = cyc + 4; full_to = cyc + 3 + stall_len; trig_stall_rd = -1;
        end
        if (rand_stall && $urandom_range(0, 2) == 0) begin
          full_from = cyc + 4; full_to = cyc + 3 + int'($urandom_range(1, 5));
        end
        if (rd_count == trig_rst_rd) begin
          rst_from = cyc + 2; rst_to = cyc + 4; trig_rst_rd = -1;
        end
      end else if (add_in_empty || deemph_out_full) begin
        gap_clean = 0;
      end
    end
    prev_reset = reset;
  endtask

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    while ((in_q.size() != 0 || in_flight) && n < budget) begin
      step();
      n++;
    end
    check("idle_in_budget", (in_q.size() == 0 && !in_flight), 1);
    repeat (3) step();
  endtask

  task automatic fresh_reset();
    rst_from = cyc + 1;
    rst_to   = cyc + 3;
    repeat (4) step();
  endtask

  task automatic expect_outs(input string tag, input int n, input int a, input int b, input int c);
    check($sformatf("%s_count", tag), outs.size(), n);
    if (outs.size() > 0 && n > 0) check($sformatf("%s_y0", tag), outs[0], a);
    if (outs.size() > 1 && n > 1) check($sformatf("%s_y1", tag), outs[1], b);
    if (outs.size() > 2 && n > 2) check($sformatf("%s_y2", tag), outs[2], c);
  endtask

  initial begin
    #1;
    check("por_rd_en", add_in_rd_en, 0);
    check("por_wr_en", deemph_out_wr_en, 0);
    check("por_dout", deemph_out_din, 0);
    repeat (4) step();

    // impulse
    outs.delete();
    in_q.push_back(1024); in_q.push_back(0); in_q.push_back(0);
    fresh_reset();
    run_idle(100);
    expect_outs("impulse", 3, 178, 293, 190);

    // step
    outs.delete();
    in_q.push_back(1024); in_q.push_back(1024);
    fresh_reset();
    run_idle(100);
    expect_outs("step", 2, 178, 471, 0);

    // rounding toward minus infinity
    outs.delete();
    in_q.push_back(-1);
    fresh_reset();
    run_idle(100);
    expect_outs("round_m1", 1, -1, 0, 0);
    outs.delete();
    in_q.push_back(-1024);
    fresh_reset();
    run_idle(100);
    expect_outs("round_m1024", 1, -178, 0, 0);

    // backpressure on the second sample's write
    outs.delete();
    trig_stall_rd = 2; stall_len = 6;
    in_q.push_back(1024); in_q.push_back(0); in_q.push_back(0);
    fresh_reset();
    run_idle(200);
    expect_outs("stall", 3, 178, 293, 190);

    // empty pulse then 8 back-to-back samples
    outs.delete();
    for (int i = 0; i < 8; i++) in_q.push_back(int'($urandom_range(0, 65535)) - 32768);
    force_empty = 1;
    fresh_reset();
    repeat (2) step();
    force_empty = 0;
    run_idle(200);
    check("burst_count", outs.size(), 8);

    // reset during CALC of the second sample
    outs.delete();
    trig_rst_rd = 2;
    in_q.push_back(1024); in_q.push_back(1024);
    fresh_reset();
    run_idle(100);
    expect_outs("rst_midop", 1, 178, 0, 0);
    outs.delete();
    in_q.push_back(1024);
    run_idle(100);
    expect_outs("after_rst", 1, 178, 0, 0);

    // randomized traffic with random empty gaps and write stalls
    outs.delete();
    fresh_reset();
    rand_empty = 1; rand_stall = 1;
    for (int i = 0; i < 60; i++) begin
      if (i % 2 == 0) in_q.push_back(int'($urandom()));
      else in_q.push_back(int'($urandom_range(0, 4095)) - 2048);
    end
    run_idle(3000);
    rand_empty = 0; rand_stall = 0; force_empty = 0;
    check("random_count", outs.size(), 60);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
